// File: rtl/mem_stage_if.sv
// Data-RAM request/ack bus between the memory stage and data memory.
// The master issues ram_en and holds it until the slave returns ram_ack.
interface mem_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ram_en;
  logic [3:0]        ram_write_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_write_data;
  logic              ram_ack;
  logic [DATA_W-1:0] ram_read_data;

  modport master (
    output ram_en, ram_write_en, ram_addr, ram_write_data,
    input  ram_ack, ram_read_data
  );

  modport slave (
    input  ram_en, ram_write_en, ram_addr, ram_write_data,
    output ram_ack, ram_read_data
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: passes ALU results through, runs loads/stores on the RAM bus.
// Optional MEM_ALIGN_CHECK_EN adds addr_error and rejects misaligned accesses.
module mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_read_flag,
  input  logic              mem_write_flag,
  input  logic              mem_sign_ext_flag,
  input  logic [3:0]        mem_sel,
  input  logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] result_in,
  input  logic              write_reg_en_in,
  input  logic [4:0]        write_reg_addr_in,
  mem_stage_if.master       ram,
  output logic              out_valid,
  output logic [DATA_W-1:0] result_out,
  output logic              write_reg_en_out,
`ifdef MEM_ALIGN_CHECK_EN
  output logic              addr_error,
`endif
  output logic [4:0]        write_reg_addr_out
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [3:0]        sel_q, sel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              store_q, store_d;
  logic              sext_q, sext_d;
  logic              wen_q, wen_d;
  logic [4:0]        waddr_q, waddr_d;
  logic              ov_q, ov_d;
  logic [DATA_W-1:0] rout_q, rout_d;
  logic              wen_out_q, wen_out_d;
  logic [4:0]        waddr_out_q, waddr_out_d;
  logic              aerr_d;

  logic              is_mem;
  logic              bad;
  logic [DATA_W-1:0] rep_data;
  logic [DATA_W-1:0] ld_val;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;

  assign is_mem = mem_read_flag | mem_write_flag;

`ifdef MEM_ALIGN_CHECK_EN
  logic       aerr_q;
  logic       legal;
  logic [1:0] low_lane;

  always_comb begin
    legal    = 1'b1;
    low_lane = 2'd0;
    case (mem_sel)
      4'b0001: low_lane = 2'd0;
      4'b0010: low_lane = 2'd1;
      4'b0100: low_lane = 2'd2;
      4'b1000: low_lane = 2'd3;
      4'b0011: low_lane = 2'd0;
      4'b1100: low_lane = 2'd2;
      4'b1111: low_lane = 2'd0;
      default: legal    = 1'b0;
    endcase
  end

  assign bad        = !legal || (low_lane != result_in[1:0]);
  assign addr_error = aerr_q;
`else
  assign bad = (mem_sel == 4'b0000);
`endif

  // Stores drive every lane; the strobes pick the ones that land.
  always_comb begin
    case (mem_sel)
      4'b0001, 4'b0010,
      4'b0100, 4'b1000: rep_data = {4{mem_write_data[7:0]}};
      4'b0011, 4'b1100: rep_data = {2{mem_write_data[15:0]}};
      default:          rep_data = mem_write_data;
    endcase
  end

  always_comb begin
    ld_b = ram.ram_read_data[7:0];
    ld_h = ram.ram_read_data[15:0];
    case (sel_q)
      4'b0010: ld_b = ram.ram_read_data[15:8];
      4'b0100: ld_b = ram.ram_read_data[23:16];
      4'b1000: ld_b = ram.ram_read_data[31:24];
      4'b1100: ld_h = ram.ram_read_data[31:16];
      default: ;
    endcase
    case (sel_q)
      4'b0001, 4'b0010, 4'b0100, 4'b1000:
        ld_val = {{24{sext_q & ld_b[7]}}, ld_b};
      4'b0011, 4'b1100:
        ld_val = {{16{sext_q & ld_h[15]}}, ld_h};
      default:
        ld_val = ram.ram_read_data;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    sel_d       = sel_q;
    wdata_d     = wdata_q;
    store_d     = store_q;
    sext_d      = sext_q;
    wen_d       = wen_q;
    waddr_d     = waddr_q;
    ov_d        = 1'b0;
    rout_d      = rout_q;
    wen_out_d   = wen_out_q;
    waddr_out_d = waddr_out_q;
    aerr_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!is_mem) begin
            ov_d        = 1'b1;
            rout_d      = result_in;
            wen_out_d   = write_reg_en_in;
            waddr_out_d = write_reg_addr_in;
          end else if (bad) begin
            ov_d        = 1'b1;
            rout_d      = result_in;
            wen_out_d   = 1'b0;
            waddr_out_d = write_reg_addr_in;
            aerr_d      = 1'b1;
          end else begin
            state_d = BUSY;
            res_d   = result_in;
            sel_d   = mem_sel;
            wdata_d = rep_data;
            store_d = mem_write_flag;
            sext_d  = mem_sign_ext_flag;
            wen_d   = write_reg_en_in;
            waddr_d = write_reg_addr_in;
          end
        end
      end
      BUSY: begin
        if (ram.ram_ack) begin
          state_d     = IDLE;
          ov_d        = 1'b1;
          rout_d      = store_q ? res_q : ld_val;
          wen_out_d   = store_q ? 1'b0 : wen_q;
          waddr_out_d = waddr_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      res_q       <= '0;
      sel_q       <= '0;
      wdata_q     <= '0;
      store_q     <= 1'b0;
      sext_q      <= 1'b0;
      wen_q       <= 1'b0;
      waddr_q     <= '0;
      ov_q        <= 1'b0;
      rout_q      <= '0;
      wen_out_q   <= 1'b0;
      waddr_out_q <= '0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      sel_q       <= sel_d;
      wdata_q     <= wdata_d;
      store_q     <= store_d;
      sext_q      <= sext_d;
      wen_q       <= wen_d;
      waddr_q     <= waddr_d;
      ov_q        <= ov_d;
      rout_q      <= rout_d;
      wen_out_q   <= wen_out_d;
      waddr_out_q <= waddr_out_d;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) aerr_q <= 1'b0;
    else     aerr_q <= aerr_d;
  end
`endif

  wire busy = (state_q == BUSY);

  assign in_ready            = !busy;
  assign ram.ram_en          = busy;
  assign ram.ram_write_en    = (busy && store_q) ? sel_q : 4'b0000;
  assign ram.ram_addr        = {res_q[ADDR_W-1:2], 2'b00};
  assign ram.ram_write_data  = wdata_q;
  assign out_valid           = ov_q;
  assign result_out          = rout_q;
  assign write_reg_en_out    = wen_out_q;
  assign write_reg_addr_out  = waddr_out_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, stores, reset abort.
// Build with +define+MEM_ALIGN_CHECK_EN to also exercise addr_error.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        mem_read_flag;
  logic        mem_write_flag;
  logic        mem_sign_ext_flag;
  logic [3:0]  mem_sel;
  logic [31:0] mem_write_data;
  logic [31:0] result_in;
  logic        write_reg_en_in;
  logic [4:0]  write_reg_addr_in;
  logic        out_valid;
  logic [31:0] result_out;
  logic        write_reg_en_out;
  logic [4:0]  write_reg_addr_out;
`ifdef MEM_ALIGN_CHECK_EN
  logic        addr_error;
`endif

  int checks = 0;
  int failures = 0;

  mem_stage_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_stage dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .mem_read_flag     (mem_read_flag),
    .mem_write_flag    (mem_write_flag),
    .mem_sign_ext_flag (mem_sign_ext_flag),
    .mem_sel           (mem_sel),
    .mem_write_data    (mem_write_data),
    .result_in         (result_in),
    .write_reg_en_in   (write_reg_en_in),
    .write_reg_addr_in (write_reg_addr_in),
    .ram               (bus.master),
    .out_valid         (out_valid),
    .result_out        (result_out),
    .write_reg_en_out  (write_reg_en_out),
`ifdef MEM_ALIGN_CHECK_EN
    .addr_error        (addr_error),
`endif
    .write_reg_addr_out(write_reg_addr_out)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    in_valid          = 1'b0;
    mem_read_flag     = 1'b0;
    mem_write_flag    = 1'b0;
    mem_sign_ext_flag = 1'b0;
    mem_sel           = 4'b0000;
    mem_write_data    = 32'h0;
    result_in         = 32'h0;
    write_reg_en_in   = 1'b0;
    write_reg_addr_in = 5'd0;
    bus.ram_ack       = 1'b0;
    bus.ram_read_data = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_in_ready got=%b exp=1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || bus.ram_en !== 1'b0) begin
      failures++;
      $display("FAIL rst_valid_en got=%b%b exp=00", out_valid, bus.ram_en);
    end
    checks++;
    if (result_out !== 32'h0 || bus.ram_addr !== 32'h0 ||
        bus.ram_write_en !== 4'h0 || write_reg_en_out !== 1'b0) begin
      failures++;
      $display("FAIL rst_outputs got=%h %h %h %b exp=0",
               result_out, bus.ram_addr, bus.ram_write_en, write_reg_en_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_nonmem_stream();
    for (int i = 1; i <= 3; i++) begin
      in_valid          = 1'b1;
      result_in         = i;
      write_reg_en_in   = 1'b1;
      write_reg_addr_in = 5'(i + 4);
      step();
      checks++;
      if (out_valid !== 1'b1 || result_out !== 32'(i) || in_ready !== 1'b1 ||
          write_reg_en_out !== 1'b1 || write_reg_addr_out !== 5'(i + 4)) begin
        failures++;
        $display("FAIL nonmem_%0d got=v%b r%h rdy%b we%b wa%0d exp=v1 r%h rdy1 we1 wa%0d",
                 i, out_valid, result_out, in_ready, write_reg_en_out,
                 write_reg_addr_out, 32'(i), i + 4);
      end
    end
    idle_inputs();
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL nonmem_drop got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_load_signed_byte();
    int lows = 0;
    in_valid          = 1'b1;
    mem_read_flag     = 1'b1;
    mem_sign_ext_flag = 1'b1;
    mem_sel           = 4'b0100;
    result_in         = 32'h0000_0102;
    write_reg_en_in   = 1'b1;
    write_reg_addr_in = 5'd7;
    step();
    idle_inputs();
    checks++;
    if (bus.ram_en !== 1'b1 || bus.ram_addr !== 32'h0000_0100 ||
        bus.ram_write_en !== 4'h0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ldb_req got=en%b a%h we%h v%b exp=en1 a00000100 we0 v0",
               bus.ram_en, bus.ram_addr, bus.ram_write_en, out_valid);
    end
    for (int c = 0; c < 3; c++) begin
      if (in_ready === 1'b0) lows++;
      if (c == 2) begin
        bus.ram_ack       = 1'b1;
        bus.ram_read_data = 32'h0080_0000;
      end
      step();
    end
    bus.ram_ack = 1'b0;
    checks++;
    if (lows != 3) begin
      failures++;
      $display("FAIL ldb_stall got=%0d exp=3", lows);
    end
    checks++;
    if (out_valid !== 1'b1 || result_out !== 32'hFFFF_FF80 ||
        write_reg_en_out !== 1'b1 || write_reg_addr_out !== 5'd7 ||
        in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ldb_result got=v%b r%h we%b wa%0d rdy%b exp=v1 rffffff80 we1 wa7 rdy1",
               out_valid, result_out, write_reg_en_out, write_reg_addr_out, in_ready);
    end
    step();
  endtask

  task automatic test_store_half();
    in_valid        = 1'b1;
    mem_write_flag  = 1'b1;
    mem_sel         = 4'b1100;
    mem_write_data  = 32'h0000_BEEF;
    result_in       = 32'h0000_0202;
    write_reg_en_in = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (bus.ram_write_data !== 32'hBEEF_BEEF || bus.ram_write_en !== 4'b1100 ||
        bus.ram_addr !== 32'h0000_0200 || bus.ram_en !== 1'b1) begin
      failures++;
      $display("FAIL sth_bus got=d%h we%b a%h en%b exp=dbeefbeef we1100 a00000200 en1",
               bus.ram_write_data, bus.ram_write_en, bus.ram_addr, bus.ram_en);
    end
    bus.ram_ack = 1'b1;
    step();
    bus.ram_ack = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || write_reg_en_out !== 1'b0 ||
        result_out !== 32'h0000_0202 || bus.ram_en !== 1'b0) begin
      failures++;
      $display("FAIL sth_done got=v%b we%b r%h en%b exp=v1 we0 r00000202 en0",
               out_valid, write_reg_en_out, result_out, bus.ram_en);
    end
    step();
  endtask

  task automatic test_store_byte();
    in_valid       = 1'b1;
    mem_write_flag = 1'b1;
    mem_read_flag  = 1'b1;
    mem_sel        = 4'b1000;
    mem_write_data = 32'h0000_00A5;
    result_in      = 32'h0000_0013;
    step();
    idle_inputs();
    checks++;
    if (bus.ram_write_data !== 32'hA5A5_A5A5 || bus.ram_write_en !== 4'b1000) begin
      failures++;
      $display("FAIL stb_bus got=d%h we%b exp=da5a5a5a5 we1000",
               bus.ram_write_data, bus.ram_write_en);
    end
    bus.ram_ack = 1'b1;
    step();
    bus.ram_ack = 1'b0;
    step();
  endtask

  task automatic test_word_load_zero_wait();
    in_valid          = 1'b1;
    mem_read_flag     = 1'b1;
    mem_sel           = 4'b1111;
    result_in         = 32'h0000_0300;
    write_reg_en_in   = 1'b1;
    write_reg_addr_in = 5'd9;
    step();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b0 || bus.ram_en !== 1'b1) begin
      failures++;
      $display("FAIL ldw_busy got=v%b en%b exp=v0 en1", out_valid, bus.ram_en);
    end
    bus.ram_ack       = 1'b1;
    bus.ram_read_data = 32'h1234_5678;
    step();
    bus.ram_ack = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result_out !== 32'h1234_5678 ||
        write_reg_addr_out !== 5'd9) begin
      failures++;
      $display("FAIL ldw_result got=v%b r%h wa%0d exp=v1 r12345678 wa9",
               out_valid, result_out, write_reg_addr_out);
    end
    step();
  endtask

  task automatic test_load_zero_ext_byte();
    in_valid          = 1'b1;
    mem_read_flag     = 1'b1;
    mem_sel           = 4'b0010;
    result_in         = 32'h0000_0401;
    write_reg_en_in   = 1'b1;
    step();
    idle_inputs();
    bus.ram_ack       = 1'b1;
    bus.ram_read_data = 32'h11FE_9922;
    step();
    bus.ram_ack = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result_out !== 32'h0000_0099) begin
      failures++;
      $display("FAIL ldbu_result got=v%b r%h exp=v1 r00000099", out_valid, result_out);
    end
    step();
  endtask

  task automatic test_stray_ack();
    bus.ram_ack = 1'b1;
    step();
    step();
    bus.ram_ack = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || bus.ram_en !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stray_ack got=v%b en%b rdy%b exp=v0 en0 rdy1",
               out_valid, bus.ram_en, in_ready);
    end
  endtask

  task automatic test_reset_busy();
    in_valid        = 1'b1;
    mem_read_flag   = 1'b1;
    mem_sel         = 4'b1111;
    result_in       = 32'h0000_0500;
    write_reg_en_in = 1'b1;
    step();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus.ram_en !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstbusy_abort got=en%b v%b rdy%b exp=en0 v0 rdy1",
               bus.ram_en, out_valid, in_ready);
    end
    bus.ram_ack       = 1'b1;
    bus.ram_read_data = 32'hDEAD_BEEF;
    step();
    bus.ram_ack = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || result_out === 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL rstbusy_late_ack got=v%b r%h exp=v0 r!=deadbeef",
               out_valid, result_out);
    end
  endtask

  task automatic test_sel_zero();
    int en_seen = 0;
    in_valid          = 1'b1;
    mem_read_flag     = 1'b1;
    mem_sel           = 4'b0000;
    result_in         = 32'h0000_0044;
    write_reg_en_in   = 1'b1;
    write_reg_addr_in = 5'd3;
    step();
    idle_inputs();
    if (bus.ram_en !== 1'b0) en_seen++;
    checks++;
    if (out_valid !== 1'b1 || write_reg_en_out !== 1'b0 ||
        result_out !== 32'h0000_0044 || en_seen != 0) begin
      failures++;
      $display("FAIL selzero got=v%b we%b r%h en%0d exp=v1 we0 r00000044 en0",
               out_valid, write_reg_en_out, result_out, en_seen);
    end
    step();
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic test_align();
    int en_seen = 0;
    in_valid          = 1'b1;
    mem_read_flag     = 1'b1;
    mem_sel           = 4'b1111;
    result_in         = 32'h0000_0002;
    write_reg_en_in   = 1'b1;
    write_reg_addr_in = 5'd4;
    step();
    idle_inputs();
    if (bus.ram_en !== 1'b0) en_seen++;
    checks++;
    if (out_valid !== 1'b1 || addr_error !== 1'b1 || write_reg_en_out !== 1'b0 ||
        result_out !== 32'h0000_0002) begin
      failures++;
      $display("FAIL align_err got=v%b ae%b we%b r%h exp=v1 ae1 we0 r00000002",
               out_valid, addr_error, write_reg_en_out, result_out);
    end
    step();
    if (bus.ram_en !== 1'b0) en_seen++;
    checks++;
    if (en_seen != 0 || addr_error !== 1'b0) begin
      failures++;
      $display("FAIL align_noreq got=en%0d ae%b exp=en0 ae0", en_seen, addr_error);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_nonmem_stream();
    test_load_signed_byte();
    test_store_half();
    test_store_byte();
    test_word_load_zero_wait();
    test_load_zero_ext_byte();
    test_stray_ack();
    test_reset_busy();
    test_sel_zero();
`ifdef MEM_ALIGN_CHECK_EN
    test_align();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
